// File: rtl/mul_pipe.sv
// mul_pipe: two-stage pipelined multiply unit for the EX stage.
//
//   Stage 1 registers the operands, op and sideband tag of an accepted op and
//   drives the combinational multiplier core from them. Stage 2 registers the
//   64-bit product and returns either the high or the low word.
//
// Ports
//   mul_clk   : clock, all state updates on the rising edge
//   reset     : asynchronous, active-high reset
//   flush     : squash every in-flight op on the next edge
//   in_valid  : op presented                  in_ready : op can be accepted
//   in_op     : 00 MUL.W, 01 MULH.W, 10 MULH.WU, 11 reserved (behaves as MUL.W)
//   in_x/in_y : rj / rk operands              in_tag   : opaque sideband
//   out_valid : result available              out_ready: consumer takes result
//   out_res   : selected 32-bit result word   out_tag  : sideband of out_res
//   busy      : any stage holds a valid op

// Combinational 32x32 multiplier: radix-4 Booth recoding of y, partial
// products accumulated into a 64-bit sum. Signed mode sign-extends both
// operands; unsigned mode zero-extends them. Only the low 64 bits of the
// extended product are kept, which equals the exact product in both modes.
module mul (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        mul_signed,
  output logic [63:0] prod
);

  logic [63:0] xe;
  logic [34:0] yb;
  logic [2:0]  sel;
  logic [63:0] mag;
  logic [63:0] pp;
  logic [63:0] acc;

  always_comb begin
    xe  = {{32{mul_signed & x[31]}}, x};
    // 34-bit two's-complement multiplier with the implicit y[-1]=0 appended.
    yb  = {{2{mul_signed & y[31]}}, y, 1'b0};
    sel = '0;
    mag = '0;
    pp  = '0;
    acc = '0;
    for (int unsigned i = 0; i < 17; i++) begin
      sel = yb[2*i +: 3];
      case (sel)
        3'b001, 3'b010, 3'b101, 3'b110: mag = xe;
        3'b011, 3'b100:                 mag = xe << 1;
        default:                        mag = '0;
      endcase
      // Negative digits (sel[2]=1) contribute the two's complement.
      pp  = sel[2] ? (~mag + 64'd1) : mag;
      acc = acc + (pp << (2*i));
    end
    prod = acc;
  end

endmodule

module mul_pipe #(
  parameter int unsigned TAG_W = 32
) (
  input  logic             mul_clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_x,
  input  logic [31:0]      in_y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_res,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULH  = 2'b01,
    OP_MULHU = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  // Stage 1
  logic             s1_valid;
  op_e              s1_op;
  logic [31:0]      s1_x;
  logic [31:0]      s1_y;
  logic [TAG_W-1:0] s1_tag;

  // Stage 2
  logic             s2_valid;
  op_e              s2_op;
  logic [63:0]      s2_prod;
  logic [TAG_W-1:0] s2_tag;

  logic             s1_adv;
  logic             s2_adv;
  logic             accept;
  logic             core_signed;
  logic [63:0]      core_prod;

  // Each stage may move whenever its downstream slot is free or being freed,
  // so a full pipe with an output handshake still accepts without a bubble.
  always_comb begin
    s2_adv   = ~s2_valid | out_ready;
    s1_adv   = ~s1_valid | s2_adv;
    in_ready = s1_adv & ~flush;
    accept   = in_valid & in_ready;
  end

  assign core_signed = (s1_op == OP_MULH);

  mul u_mul (
    .x          (s1_x),
    .y          (s1_y),
    .mul_signed (core_signed),
    .prod       (core_prod)
  );

  // Valid bits: flush overrides any advance.
  always_ff @(posedge mul_clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s2_adv) s2_valid <= s1_valid;
      if (s1_adv) s1_valid <= accept;
    end
  end

  // Stage 1 data: loads only on an accepted op, otherwise holds.
  always_ff @(posedge mul_clk or posedge reset) begin
    if (reset) begin
      s1_op  <= OP_MUL;
      s1_x   <= '0;
      s1_y   <= '0;
      s1_tag <= '0;
    end else if (accept) begin
      s1_op  <= op_e'(in_op);
      s1_x   <= in_x;
      s1_y   <= in_y;
      s1_tag <= in_tag;
    end
  end

  // Stage 2 data: loads when stage 2 advances and stage 1 carries an op.
  always_ff @(posedge mul_clk or posedge reset) begin
    if (reset) begin
      s2_op   <= OP_MUL;
      s2_prod <= '0;
      s2_tag  <= '0;
    end else if (s2_adv && s1_valid) begin
      s2_op   <= s1_op;
      s2_prod <= core_prod;
      s2_tag  <= s1_tag;
    end
  end

  always_comb begin
    out_valid = s2_valid;
    out_tag   = s2_tag;
    busy      = s1_valid | s2_valid;
    case (s2_op)
      OP_MULH, OP_MULHU: out_res = s2_prod[63:32];
      default:           out_res = s2_prod[31:0];
    endcase
  end

endmodule

// File: tb/tb_mul_pipe.sv
module tb_mul_pipe;

  localparam int unsigned TAG_W = 32;

  logic             mul_clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_x;
  logic [31:0]      in_y;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_res;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  int total = 0;
  int bad   = 0;

  mul_pipe #(.TAG_W(TAG_W)) dut (
    .mul_clk   (mul_clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  always #5 mul_clk = ~mul_clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model built from plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] x,
                                        input logic [31:0] y);
    logic [63:0] p;
    case (op)
      2'b01: begin
        p = 64'($signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}));
        return p[63:32];
      end
      2'b10: begin
        p = {32'b0, x} * {32'b0, y};
        return p[63:32];
      end
      default: begin
        p = {32'b0, x} * {32'b0, y};
        return p[31:0];
      end
    endcase
  endfunction

  task automatic drive_vec(input int i, input logic [TAG_W-1:0] tag);
    in_valid = 1'b1;
    in_op    = vecs[i].op;
    in_x     = vecs[i].x;
    in_y     = vecs[i].y;
    in_tag   = tag;
  endtask

  logic [63:0] q[$];
  logic [63:0] ent;
  logic        acc_pend;
  int          got;
  int          issued;
  logic [31:0] hold_res;
  logic [TAG_W-1:0] hold_tag;

  initial begin
    vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[2]  = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[3]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[4]  = '{2'b10, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[5]  = '{2'b00, 32'h7FFFFFFF, 32'h00000002, 32'hFFFFFFFE};
    vecs[6]  = '{2'b01, 32'h7FFFFFFF, 32'h00000002, 32'h00000000};
    vecs[7]  = '{2'b11, 32'h00000003, 32'h00000005, 32'h0000000F};
    vecs[8]  = '{2'b01, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF};
    vecs[9]  = '{2'b10, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    vecs[10] = '{2'b10, 32'h00010000, 32'h00010000, 32'h00000001};
    vecs[11] = '{2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0;
    in_x = '0; in_y = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(negedge mul_clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_res", out_res, 0);
    chk("rst_out_tag", out_tag, 0);
    reset = 1'b0;
    #1 chk("rst_in_ready", in_ready, 1);

    // Single ops: latency and value of each table entry.
    for (int i = 0; i < NV; i++) begin
      @(negedge mul_clk);
      drive_vec(i, TAG_W'(100 + i));
      #1 chk("idle_in_ready", in_ready, 1);
      @(negedge mul_clk);
      in_valid = 1'b0;
      chk("lat1_out_valid", out_valid, 0);
      @(negedge mul_clk);
      chk("lat2_out_valid", out_valid, 1);
      chk($sformatf("vec%0d_res", i), out_res, vecs[i].exp);
      chk($sformatf("vec%0d_tag", i), out_tag, 100 + i);
    end

    // Back-to-back 8 ops with out_ready=1: gapless, in order.
    @(negedge mul_clk);
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) @(negedge mul_clk);
      chk("b2b_out_valid", out_valid, (k >= 2 && k <= 9) ? 1 : 0);
      if (k >= 2 && k <= 9) begin
        chk("b2b_res", out_res, vecs[k-2].exp);
        chk("b2b_tag", out_tag, 200 + k - 2);
      end
      if (k < 8) drive_vec(k, TAG_W'(200 + k));
      else in_valid = 1'b0;
    end

    // Backpressure: 3 ops issued with out_ready=0.
    @(negedge mul_clk);
    out_ready = 1'b0;
    drive_vec(0, TAG_W'(300));
    @(negedge mul_clk);
    chk("bp_in_ready1", in_ready, 1);
    drive_vec(2, TAG_W'(301));
    @(negedge mul_clk);
    drive_vec(5, TAG_W'(302));
    hold_res = out_res;
    hold_tag = out_tag;
    chk("bp_first_res", out_res, vecs[0].exp);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_res_stable", out_res, hold_res);
      chk("bp_tag_stable", out_tag, hold_tag);
      @(negedge mul_clk);
    end
    q.delete();
    q.push_back({32'd300, vecs[0].exp});
    q.push_back({32'd301, vecs[2].exp});
    q.push_back({32'd302, vecs[5].exp});
    out_ready = 1'b1;
    acc_pend = 1'b0;
    got = 0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      if (c > 0) @(negedge mul_clk);
      if (acc_pend) in_valid = 1'b0;
      #1;
      acc_pend = in_valid && in_ready;
      if (out_valid && out_ready) begin
        ent = q.pop_front();
        chk("bp_drain_res", out_res, ent[31:0]);
        chk("bp_drain_tag", out_tag, ent[63:32]);
        got++;
      end
    end
    chk("bp_count", got, 3);
    @(negedge mul_clk);
    in_valid = 1'b0;

    // Flush with both stages full and a new op offered.
    @(negedge mul_clk);
    out_ready = 1'b0;
    drive_vec(1, TAG_W'(400));
    @(negedge mul_clk);
    drive_vec(3, TAG_W'(401));
    @(negedge mul_clk);
    drive_vec(4, TAG_W'(402));
    flush = 1'b1;
    #1 chk("flush_in_ready", in_ready, 0);
    chk("flush_pre_busy", busy, 1);
    @(negedge mul_clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_busy", busy, 0);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge mul_clk);
      chk("flush_no_stale", out_valid, 0);
    end

    // Reset while an op sits in stage 1.
    drive_vec(6, TAG_W'(500));
    @(negedge mul_clk);
    in_valid = 1'b0;
    chk("prerst_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    @(negedge mul_clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge mul_clk);
      chk("postrst_out_valid", out_valid, 0);
    end

    // Random ops, random consumer stalls, checked against the model.
    q.delete();
    acc_pend = 1'b0;
    issued = 0;
    got = 0;
    for (int c = 0; c < 3000 && !(issued == 200 && q.size() == 0); c++) begin
      @(negedge mul_clk);
      if (acc_pend) in_valid = 1'b0;
      if (!in_valid && issued < 200 && $urandom_range(3) != 0) begin
        in_valid = 1'b1;
        in_op    = 2'($urandom_range(3));
        case ($urandom_range(3))
          0: in_x = 32'h80000000;
          1: in_x = 32'hFFFFFFFF;
          default: in_x = $urandom;
        endcase
        in_y   = ($urandom_range(4) == 0) ? 32'h7FFFFFFF : $urandom;
        in_tag = $urandom;
      end
      out_ready = ($urandom_range(2) != 0);
      #1;
      acc_pend = in_valid && in_ready;
      if (acc_pend) begin
        q.push_back({in_tag, model(in_op, in_x, in_y)});
        issued++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rand_spurious", 1, 0);
        end else begin
          ent = q.pop_front();
          chk("rand_res", out_res, ent[31:0]);
          chk("rand_tag", out_tag, ent[63:32]);
          got++;
        end
      end
    end
    chk("rand_issued", issued, 200);
    chk("rand_delivered", got, 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
